boss_engine: RTL
================

// Module: boss_engine
// PURPOSE
//  Next-generation boss controller. Owns its own movement FSM (patrol/dive/rise/hold) rather than taking external phase strobes.
//  Performs AABB collision of the boss against NUM_LASERS player lasers and the player ship, and tracks health with invincibility frames.
//  Sits between the laser/ship blocks and the sprite/colour mapper; advances once per frame_clk.
// PARAMETERS
//  NUM_LASERS    4    player laser channels checked
//  BOSS_W        250  boss width (px)
//  BOSS_H        111  boss height (px)
//  SHIP_W/SHIP_H 30   player ship box (px)
//  MAX_HP        200  health loaded on spawn (must fit in 10 bits)
//  SPAWN_X/Y     270/10  position loaded on spawn
//  X_MIN/X_MAX   0/639   horizontal screen limits
//  TOP_Y         10   rise stop line
//  FLOOR_Y       379  dive stop line
//  PATROL_SPD    2    px/frame in PATROL
//  DIVE_SPD      10   px/frame in DIVE
//  RISE_SPD      2    px/frame in RISE
//  PATROL_FRAMES 240  frames in PATROL before DIVE
//  HOLD_FRAMES   60   frames in HOLD
//  IFRAMES       8    frames after a damaging hit during which lasers are ignored
// PORTS
//  frame_clk     in   1              frame clock; all state changes on its rising edge
//  Reset_n       in   1              asynchronous, active-low reset
//  spawn         in   1              start or restart the boss (honoured only in IDLE or DEAD)
//  difficulty    in   3              one-hot; bit1 -> dmg 2, else bit2 -> dmg 1, else dmg 4
//  laser_width   in   10             laser box width
//  laser_height  in   10             laser box height
//  laser_valid   in   NUM_LASERS     laser i exists
//  laser_x       in   10*NUM_LASERS  laser i X at [10i+9:10i]
//  laser_y       in   10*NUM_LASERS  laser i Y at [10i+9:10i]
//  PSX, PSY      in   10             ship top-left corner
//  BossX, BossY  out  10             boss top-left corner (registered)
//  Bosswidth     out  10             constant BOSS_W
//  Bossheight    out  10             constant BOSS_H
//  health        out  10             remaining HP
//  laser_hit     out  NUM_LASERS     one-frame pulse; laser i struck the boss (laser block despawns it)
//  hit_ship      out  1              boss overlaps ship this frame
//  beat_boss     out  1              level; health reached 0
//  phase         out  3              IDLE=0 PATROL=1 DIVE=2 RISE=3 HOLD=4 DEAD=5
// BEHAVIOUR
//  Reset values: phase=IDLE, BossX=639, BossY=0, health=0, all outputs 0, direction=+X, counters=0.
//  Overlap test: A and B overlap iff A.x <= B.x+B.w, B.x <= A.x+A.w, and the same holds in Y.
//   Compute in 11 bits so +width never wraps; edge contact counts as a hit.
//  Collision uses the current registered BossX/BossY.
//  Results are registered, so laser_hit/hit_ship/health update 1 frame after the overlapping position is presented.
//  Collision is active only in PATROL, DIVE, RISE and HOLD; in IDLE and DEAD, laser_hit=0 and hit_ship=0.
//  Damage: k = popcount(valid & overlapping lasers); applied only when k>0 and iframe counter=0.
//   Damage amount is k*dmg, saturating at 0.
//   laser_hit pulses for each of the k lasers, including hits absorbed during iframes.
//   A damaging hit loads the iframe counter with IFRAMES; the counter decrements by 1 per frame down to 0.
//  When health becomes 0: next phase=DEAD, beat_boss=1 (held until spawn or reset), position frozen.
//  FSM:
//   IDLE: spawn -> PATROL. Load SPAWN_X/Y and MAX_HP; clear beat_boss, iframe counter, and frame counter.
//   PATROL: X += +/-PATROL_SPD.
//    If X-PATROL_SPD < X_MIN, clamp to X_MIN and set dir=+.
//    If X+BOSS_W+PATROL_SPD > X_MAX, clamp to X_MAX-BOSS_W and set dir=-.
//    After PATROL_FRAMES frames -> DIVE.
//   DIVE: Y += DIVE_SPD. When the new Y >= FLOOR_Y, clamp to FLOOR_Y -> RISE.
//   RISE: Y -= RISE_SPD. When the new Y <= TOP_Y, clamp to TOP_Y -> HOLD.
//   HOLD: no motion for HOLD_FRAMES frames -> PATROL (frame counter cleared, dir kept).
//   DEAD: no motion; spawn -> PATROL with full respawn load (same as from IDLE).
//  Precedence:
//   - Death overrides any phase transition in the same frame.
//   - spawn is ignored in the active phases.
//  Reset asserted mid-operation returns immediately to reset values (async); there is no partial state.
//  The frame counter is 9 bits and never wraps: it clears on every phase entry.
// TESTING
//  Reset: hold Reset_n=0 -> BossX=639, BossY=0, phase=0, health=0, beat_boss=0; release; no spawn -> stays IDLE.
//  Spawn/patrol: spawn 1 frame -> BossX=270, BossY=10, health=200, phase=1.
//   X ramps +2/frame; clamps at 389 and reverses; DIVE after 240 frames.
//  Dive/rise/hold: Y 10->20..->379 clamp, RISE -2/frame to 10, HOLD 60 frames, back to PATROL.
//   Phase trace must match exactly.
//  Multi-hit: difficulty=001, lasers 0 and 2 overlap in the same frame -> laser_hit=0101, health 200->192.
//   A hit on the next frame -> laser_hit pulse, health unchanged (iframes).
//  Death: difficulty=010, health=1 via repeated hits -> health=0 (no underflow), phase=5, beat_boss=1.
//   Lasers ignored; spawn -> full respawn.
//  Edge contact and reset mid-DIVE: laser at X=BossX+250 -> hit registered.
//   Assert Reset_n low during DIVE -> reset values immediately.

Source files
------------

// File: rtl/boss_engine.sv
// boss_engine: self-driven boss controller for one video frame per frame_clk.
// Owns the patrol/dive/rise/hold movement FSM, checks the boss box against the
// player lasers and ship, and tracks health with invincibility frames.
// The phase output is the FSM state itself, so it doubles as the debug view.
module boss_engine #(
    parameter int NUM_LASERS    = 4,
    parameter int BOSS_W        = 250,
    parameter int BOSS_H        = 111,
    parameter int SHIP_W        = 30,
    parameter int SHIP_H        = 30,
    parameter int MAX_HP        = 200,
    parameter int SPAWN_X       = 270,
    parameter int SPAWN_Y       = 10,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int TOP_Y         = 10,
    parameter int FLOOR_Y       = 379,
    parameter int PATROL_SPD    = 2,
    parameter int DIVE_SPD      = 10,
    parameter int RISE_SPD      = 2,
    parameter int PATROL_FRAMES = 240,
    parameter int HOLD_FRAMES   = 60,
    parameter int IFRAMES       = 8
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic                      spawn,
    input  logic [2:0]                difficulty,
    input  logic [9:0]                laser_width,
    input  logic [9:0]                laser_height,
    input  logic [NUM_LASERS-1:0]     laser_valid,
    input  logic [10*NUM_LASERS-1:0]  laser_x,
    input  logic [10*NUM_LASERS-1:0]  laser_y,
    input  logic [9:0]                PSX,
    input  logic [9:0]                PSY,
    output logic [9:0]                BossX,
    output logic [9:0]                BossY,
    output logic [9:0]                Bosswidth,
    output logic [9:0]                Bossheight,
    output logic [9:0]                health,
    output logic [NUM_LASERS-1:0]     laser_hit,
    output logic                      hit_ship,
    output logic                      beat_boss,
    output logic [2:0]                phase
);

    localparam int KW  = $clog2(NUM_LASERS + 1);
    localparam int IFW = $clog2(IFRAMES + 1);

    // 11-bit versions so that position + size never wraps
    localparam logic [10:0] BW11    = 11'(BOSS_W);
    localparam logic [10:0] BH11    = 11'(BOSS_H);
    localparam logic [10:0] SW11    = 11'(SHIP_W);
    localparam logic [10:0] SH11    = 11'(SHIP_H);
    localparam logic [10:0] XMIN11  = 11'(X_MIN);
    localparam logic [10:0] XMAX11  = 11'(X_MAX);
    localparam logic [10:0] PSPD11  = 11'(PATROL_SPD);
    localparam logic [10:0] DSPD11  = 11'(DIVE_SPD);
    localparam logic [10:0] RSPD11  = 11'(RISE_SPD);
    localparam logic [10:0] TOP11   = 11'(TOP_Y);
    localparam logic [10:0] FLOOR11 = 11'(FLOOR_Y);

    localparam logic [9:0] PSPD10   = 10'(PATROL_SPD);
    localparam logic [9:0] RSPD10   = 10'(RISE_SPD);
    localparam logic [9:0] XMIN10   = 10'(X_MIN);
    localparam logic [9:0] XRIGHT10 = 10'(X_MAX - BOSS_W);
    localparam logic [9:0] TOP10    = 10'(TOP_Y);
    localparam logic [9:0] FLOOR10  = 10'(FLOOR_Y);
    localparam logic [9:0] SPX10    = 10'(SPAWN_X);
    localparam logic [9:0] SPY10    = 10'(SPAWN_Y);
    localparam logic [9:0] HP10     = 10'(MAX_HP);

    localparam logic [8:0]     PATROL_LAST = 9'(PATROL_FRAMES - 1);
    localparam logic [8:0]     HOLD_LAST   = 9'(HOLD_FRAMES - 1);
    localparam logic [IFW-1:0] IFR_LOAD    = IFW'(IFRAMES);
    localparam logic [IFW-1:0] IFR_ONE     = IFW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PATROL = 3'd1,
        S_DIVE   = 3'd2,
        S_RISE   = 3'd3,
        S_HOLD   = 3'd4,
        S_DEAD   = 3'd5
    } phase_t;

    phase_t                state_q, state_d;
    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;
    logic [9:0]            hp_q, hp_d;
    logic                  dir_q, dir_d;      // 1 = moving +X
    logic [8:0]            cnt_q, cnt_d;      // frames spent in PATROL/HOLD
    logic [IFW-1:0]        ifr_q, ifr_d;      // invincibility frames left
    logic [NUM_LASERS-1:0] hit_q, hit_d;
    logic                  ship_q, ship_d;
    logic                  beat_q, beat_d;

    logic [NUM_LASERS-1:0] ovl;
    logic [KW-1:0]         k;
    logic                  ship_ovl;
    logic [2:0]            dmg;
    logic [10:0]           dmg_amt;
    logic [10:0]           dive_y;
    logic                  active;

    // Inclusive AABB test: touching edges count as overlap
    function automatic logic overlap(input logic [10:0] ax, input logic [10:0] ay,
                                     input logic [10:0] aw, input logic [10:0] ah,
                                     input logic [10:0] bx, input logic [10:0] by,
                                     input logic [10:0] bw, input logic [10:0] bh);
        return (ax <= bx + bw) && (bx <= ax + aw) && (ay <= by + bh) && (by <= ay + ah);
    endfunction

    // Per-laser overlap against the current boss position, and the hit count
    always_comb begin
        ovl = '0;
        k   = '0;
        for (int i = 0; i < NUM_LASERS; i++) begin
            ovl[i] = laser_valid[i] &&
                     overlap({1'b0, x_q}, {1'b0, y_q}, BW11, BH11,
                             {1'b0, laser_x[10*i +: 10]}, {1'b0, laser_y[10*i +: 10]},
                             {1'b0, laser_width}, {1'b0, laser_height});
            k = k + KW'(ovl[i]);
        end
    end

    // Damage per laser from the difficulty one-hot (bit1 wins over bit2)
    always_comb begin
        if (difficulty[1])      dmg = 3'd2;
        else if (difficulty[2]) dmg = 3'd1;
        else                    dmg = 3'd4;
    end

    assign ship_ovl = overlap({1'b0, x_q}, {1'b0, y_q}, BW11, BH11,
                              {1'b0, PSX}, {1'b0, PSY}, SW11, SH11);
    assign dmg_amt  = 11'(k) * 11'(dmg);
    assign dive_y   = {1'b0, y_q} + DSPD11;
    assign active   = (state_q == S_PATROL) || (state_q == S_DIVE) ||
                      (state_q == S_RISE)   || (state_q == S_HOLD);

    // Next-state: spawn handling, damage/iframes, death, then phase motion
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hp_d    = hp_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        ifr_d   = ifr_q;
        hit_d   = '0;
        ship_d  = 1'b0;
        beat_d  = beat_q;

        if (!active) begin
            // IDLE and DEAD only listen for spawn; direction is kept as-is
            if (spawn) begin
                state_d = S_PATROL;
                x_d     = SPX10;
                y_d     = SPY10;
                hp_d    = HP10;
                beat_d  = 1'b0;
                ifr_d   = '0;
                cnt_d   = '0;
            end
        end else begin
            hit_d  = ovl;
            ship_d = ship_ovl;

            if ((k != '0) && (ifr_q == '0)) begin
                if (dmg_amt >= {1'b0, hp_q}) hp_d = '0;
                else                         hp_d = hp_q - dmg_amt[9:0];
                ifr_d = IFR_LOAD;
            end else if (ifr_q != '0) begin
                ifr_d = ifr_q - IFR_ONE;
            end

            if (hp_d == '0) begin
                // Death wins over any movement or phase change this frame
                state_d = S_DEAD;
                beat_d  = 1'b1;
            end else begin
                case (state_q)
                    S_PATROL: begin
                        if (dir_q) begin
                            if ({1'b0, x_q} + BW11 + PSPD11 > XMAX11) begin
                                x_d   = XRIGHT10;
                                dir_d = 1'b0;
                            end else begin
                                x_d = x_q + PSPD10;
                            end
                        end else begin
                            if ({1'b0, x_q} < XMIN11 + PSPD11) begin
                                x_d   = XMIN10;
                                dir_d = 1'b1;
                            end else begin
                                x_d = x_q - PSPD10;
                            end
                        end
                        if (cnt_q == PATROL_LAST) begin
                            state_d = S_DIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 9'd1;
                        end
                    end
                    S_DIVE: begin
                        if (dive_y >= FLOOR11) begin
                            y_d     = FLOOR10;
                            state_d = S_RISE;
                            cnt_d   = '0;
                        end else begin
                            y_d = dive_y[9:0];
                        end
                    end
                    S_RISE: begin
                        if ({1'b0, y_q} <= TOP11 + RSPD11) begin
                            y_d     = TOP10;
                            state_d = S_HOLD;
                            cnt_d   = '0;
                        end else begin
                            y_d = y_q - RSPD10;
                        end
                    end
                    S_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = S_PATROL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 9'd1;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            x_q     <= 10'd639;
            y_q     <= 10'd0;
            hp_q    <= 10'd0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
            ifr_q   <= '0;
            hit_q   <= '0;
            ship_q  <= 1'b0;
            beat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hp_q    <= hp_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            ifr_q   <= ifr_d;
            hit_q   <= hit_d;
            ship_q  <= ship_d;
            beat_q  <= beat_d;
        end
    end

    assign BossX      = x_q;
    assign BossY      = y_q;
    assign Bosswidth  = 10'(BOSS_W);
    assign Bossheight = 10'(BOSS_H);
    assign health     = hp_q;
    assign laser_hit  = hit_q;
    assign hit_ship   = ship_q;
    assign beat_boss  = beat_q;
    assign phase      = state_q;

endmodule
